ltc2600_write: RTL and testbench

LTC2600_WRITE -- requirements
Module: ltc2600_write

---
 rtl/ltc2600_write_if.sv | 37 +++
 rtl/ltc2600_write.sv | 98 +++++++++
 tb/tb_ltc2600_write.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ltc2600_write_if.sv
// rtl/ltc2600_write_if.sv - command/serial bundle for the LTC2600 DAC writer
//
// Purpose: groups the write request inputs and the DAC serial outputs of
// ltc2600_write into one bundle.
// Signals:
//   send_new_cmd    request; a rising edge starts one write
//   command[3:0]    LTC2600 command nibble C3..C0
//   address[3:0]    LTC2600 address nibble A3..A0
//   data[DW-1:0]    DAC code
//   sck, sdi        serial clock and data to the DAC (MSB first)
//   csb             active-low chip select / load
//   clrb            active-low DAC clear
//   write_complete  one-cycle pulse when a write finishes
// Modports: master drives the request side, slave is the writer itself.
interface ltc2600_write_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  send_new_cmd;
  logic [3:0]            command;
  logic [3:0]            address;
  logic [DATA_WIDTH-1:0] data;
  logic                  sck;
  logic                  sdi;
  logic                  csb;
  logic                  clrb;
  logic                  write_complete;

  modport master (
    output send_new_cmd, command, address, data,
    input  sck, sdi, csb, clrb, write_complete
  );

  modport slave (
    input  send_new_cmd, command, address, data,
    output sck, sdi, csb, clrb, write_complete
  );
endinterface

// File: rtl/ltc2600_write.sv
// rtl/ltc2600_write.sv - serial word writer for the LTC2600 DAC
//
// Purpose: on a rising edge of send_new_cmd, shifts the word
// {command, address, data} (8 + DATA_WIDTH bits) MSB first to the DAC with a
// 2-cycle sck, then raises csb to latch it and pulses write_complete.
// Ports:
//   clk   system clock, all state changes on its rising edge
//   rst   asynchronous active-high reset (aborts any write in flight)
//   bus   ltc2600_write_if slave: request inputs and DAC serial outputs
module ltc2600_write #(
  parameter int DATA_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  ltc2600_write_if.slave  bus
);
  localparam int W  = 8 + DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t        state;
  logic          send_prev;
  logic          start;
  // Holds the bits still to be sent; the MSB goes straight to sdi at start.
  logic [W-2:0]  rest_bits;
  logic [CW-1:0] bit_cnt;
  logic          sck_r;
  logic          sdi_r;
  logic          csb_r;
  logic          wc_r;

  // send_prev tracks the input in every state, so a level still high when a
  // write ends never retriggers, and edges during a write are dropped.
  assign start = bus.send_new_cmd & ~send_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      send_prev <= 1'b0;
      rest_bits <= '0;
      bit_cnt   <= '0;
      sck_r     <= 1'b0;
      sdi_r     <= 1'b0;
      csb_r     <= 1'b1;
      wc_r      <= 1'b0;
    end else begin
      send_prev <= bus.send_new_cmd;
      case (state)
        IDLE: begin
          sck_r <= 1'b0;
          sdi_r <= 1'b0;
          csb_r <= 1'b1;
          wc_r  <= 1'b0;
          if (start) begin
            rest_bits <= {bus.command[2:0], bus.address, bus.data};
            sdi_r     <= bus.command[3];
            csb_r     <= 1'b0;
            bit_cnt   <= '0;
            state     <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          // DAC samples sdi on this rising sck edge.
          sck_r <= 1'b1;
          state <= SHIFT_HI;
        end
        SHIFT_HI: begin
          // sdi only moves together with the falling sck edge.
          sck_r <= 1'b0;
          if (bit_cnt == CW'(W - 1)) begin
            sdi_r <= 1'b0;
            state <= LATCH;
          end else begin
            sdi_r     <= rest_bits[W-2];
            rest_bits <= {rest_bits[W-3:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
            state     <= SHIFT_LO;
          end
        end
        LATCH: begin
          csb_r <= 1'b1;
          wc_r  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sck            = sck_r;
  assign bus.sdi            = sdi_r;
  assign bus.csb            = csb_r;
  assign bus.write_complete = wc_r;
  // The clear line follows reset directly, so the DAC is cleared as long as
  // rst is held and released the moment it drops.
  assign bus.clrb           = ~rst;
endmodule

// File: tb/tb_ltc2600_write.sv
// tb/tb_ltc2600_write.sv - self-checking bench for ltc2600_write
module tb_ltc2600_write;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  ltc2600_write_if #(.DATA_WIDTH(16)) if16();
  ltc2600_write_if #(.DATA_WIDTH(12)) if12();

  ltc2600_write #(.DATA_WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  ltc2600_write #(.DATA_WIDTH(12)) dut12 (.clk(clk), .rst(rst), .bus(if12));

  // Instance 0 = 16-bit data (24-bit word), instance 1 = 12-bit data (20-bit word)
  wire [1:0] o_sck  = {if12.sck, if16.sck};
  wire [1:0] o_sdi  = {if12.sdi, if16.sdi};
  wire [1:0] o_csb  = {if12.csb, if16.csb};
  wire [1:0] o_wc   = {if12.write_complete, if16.write_complete};
  wire [1:0] o_clrb = {if12.clrb, if16.clrb};
  wire [1:0] i_send = {if12.send_new_cmd, if16.send_new_cmd};
  logic [23:0] in_word [2];
  assign in_word[0] = {if16.command, if16.address, if16.data};
  assign in_word[1] = {4'h0, if12.command, if12.address, if12.data};

  function automatic int wlen(input int i);
    return (i == 0) ? 24 : 20;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Timing model: a write is a frame of 2W+2 cycles counted from the start
  // edge. Phase k < 2W shifts bit W-1-k/2 with sck high on odd k, phase 2W
  // is the idle gap, phase 2W+1 raises csb together with the completion pulse.
  logic [1:0]  m_active = 2'b00;
  logic [1:0]  m_prev = 2'b00;
  int          m_phase [2];
  logic [23:0] m_word [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_active[i] <= 1'b0;
        m_prev[i]   <= 1'b0;
        m_phase[i]  <= 0;
      end else begin
        m_prev[i] <= i_send[i];
        if (m_active[i] && m_phase[i] < 2 * wlen(i) + 1) begin
          m_phase[i] <= m_phase[i] + 1;
        end else if (i_send[i] && !m_prev[i]) begin
          m_active[i] <= 1'b1;
          m_phase[i]  <= 0;
          m_word[i]   <= in_word[i];
        end else begin
          m_active[i] <= 1'b0;
        end
      end
    end
  end

  // Returns {sck, sdi, csb, write_complete}
  function automatic logic [3:0] expect_out(input int i);
    int w;
    int k;
    w = wlen(i);
    k = m_phase[i];
    if (rst || !m_active[i]) return 4'b0010;
    if (k < 2 * w) return {k[0], m_word[i][w - 1 - k / 2], 2'b00};
    if (k == 2 * w) return 4'b0000;
    return 4'b0011;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("outs%0d{sck,sdi,csb,wc}", i),
            {o_sck[i], o_sdi[i], o_csb[i], o_wc[i]}, expect_out(i));
      check($sformatf("clrb%0d", i), o_clrb[i], !rst);
    end
  end

  // Frame monitor: what the DAC would have received
  logic [1:0]  p_sck = 2'b00;
  logic [1:0]  p_csb = 2'b11;
  logic [23:0] cap [2];
  int          rises [2];
  int          low_len [2];
  logic [23:0] done_word [2];
  int          done_rises [2];
  int          done_low [2];
  int          n_frames [2];
  int          n_pulses [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0; low_len[i] = 0; n_frames[i] = 0; n_pulses[i] = 0;
      done_rises[i] = 0; done_low[i] = 0; cap[i] = '0; done_word[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      p_sck[i] <= o_sck[i];
      p_csb[i] <= o_csb[i];
      if (o_wc[i]) n_pulses[i] <= n_pulses[i] + 1;
      if (!o_csb[i]) begin
        if (p_csb[i]) begin
          cap[i]     <= '0;
          rises[i]   <= 0;
          low_len[i] <= 1;
        end else begin
          low_len[i] <= low_len[i] + 1;
          if (o_sck[i] && !p_sck[i]) begin
            cap[i]   <= {cap[i][22:0], o_sdi[i]};
            rises[i] <= rises[i] + 1;
          end
        end
      end else if (!p_csb[i]) begin
        done_word[i]  <= cap[i];
        done_rises[i] <= rises[i];
        done_low[i]   <= low_len[i];
        n_frames[i]   <= n_frames[i] + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int i, input int n);
    int c;
    c = 0;
    while (n_frames[i] < n && c < 300) begin
      tick();
      c++;
    end
    check("wait_frames", n_frames[i] >= n, 1);
  endtask

  task automatic wait_rises(input int i, input int n);
    int c;
    c = 0;
    while (!(o_csb[i] == 1'b0 && rises[i] >= n) && c < 300) begin
      tick();
      c++;
    end
    check("wait_rises", rises[i] >= n, 1);
  endtask

  initial begin
    if16.send_new_cmd = 0; if16.command = 0; if16.address = 0; if16.data = 0;
    if12.send_new_cmd = 0; if12.command = 0; if12.address = 0; if12.data = 0;
    repeat (3) tick();
    check("rst_csb", if16.csb, 1);
    check("rst_sck", if16.sck, 0);
    check("rst_sdi", if16.sdi, 0);
    check("rst_clrb", if16.clrb, 0);
    check("rst_wc", if16.write_complete, 0);
    rst = 0;
    repeat (2) tick();
    check("clrb_after_rst", if16.clrb, 1);

    // Level held high for three cycles: exactly one write
    if16.command = 4'b0001; if16.address = 4'b1000; if16.data = 16'hAAAA;
    if16.send_new_cmd = 1;
    repeat (3) tick();
    if16.send_new_cmd = 0;
    wait_frames(0, 1);
    repeat (60) tick();
    check("w1_word", done_word[0], 24'h18AAAA);
    check("w1_rises", done_rises[0], 24);
    check("w1_csb_low", done_low[0], 49);
    check("w1_pulses", n_pulses[0], 1);
    check("w1_frames", n_frames[0], 1);

    // Back-to-back second write
    if16.command = 4'b0011; if16.address = 4'b1111; if16.data = 16'hFFFF;
    if16.send_new_cmd = 1;
    tick();
    if16.send_new_cmd = 0;
    wait_frames(0, 2);
    check("w2_word", done_word[0], 24'h3FFFFF);
    check("w2_pulses", n_pulses[0], 2);

    // New edge and input changes mid-write are ignored; level still high at
    // the end does not retrigger
    if16.command = 4'h2; if16.address = 4'h4; if16.data = 16'h1234;
    if16.send_new_cmd = 1;
    wait_rises(0, 5);
    if16.send_new_cmd = 0;
    tick();
    if16.send_new_cmd = 1;
    if16.command = 4'hF; if16.address = 4'hF; if16.data = 16'h0000;
    wait_frames(0, 3);
    repeat (60) tick();
    check("w3_word", done_word[0], 24'h241234);
    check("w3_pulses", n_pulses[0], 3);
    check("w3_frames", n_frames[0], 3);
    if16.send_new_cmd = 0;
    tick();

    // Reset mid-write aborts without a completion pulse
    if16.command = 4'h3; if16.address = 4'h1; if16.data = 16'h5555;
    if16.send_new_cmd = 1;
    tick();
    if16.send_new_cmd = 0;
    wait_rises(0, 10);
    rst = 1;
    #1;
    check("abort_csb", if16.csb, 1);
    check("abort_sck", if16.sck, 0);
    check("abort_clrb", if16.clrb, 0);
    check("abort_wc", if16.write_complete, 0);
    repeat (2) tick();
    rst = 0;
    repeat (40) tick();
    check("abort_frames", n_frames[0], 4);
    check("abort_rises", done_rises[0], 10);
    check("abort_pulses", n_pulses[0], 3);
    if16.send_new_cmd = 1;
    tick();
    if16.send_new_cmd = 0;
    wait_frames(0, 5);
    check("w4_word", done_word[0], 24'h315555);
    check("w4_rises", done_rises[0], 24);
    check("w4_pulses", n_pulses[0], 4);

    // 12-bit data instance
    if12.command = 4'h3; if12.address = 4'h0; if12.data = 12'h800;
    if12.send_new_cmd = 1;
    tick();
    if12.send_new_cmd = 0;
    wait_frames(1, 1);
    repeat (5) tick();
    check("dw12_word", done_word[1], 24'h030800);
    check("dw12_rises", done_rises[1], 20);
    check("dw12_csb_low", done_low[1], 41);
    check("dw12_pulses", n_pulses[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
